// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, serializer timing constants, byte type.
// No logic; consumed by the TX arbiter and related UART blocks.
// Timing constants describe the 100 MHz / 9600 baud / 16x oversampled serializer.
package uart_pkg;

  localparam int unsigned CLK_HZ        = 100_000_000;
  localparam int unsigned BAUD_RATE     = 9600;
  localparam int unsigned OVERSAMPLE    = 16;
  localparam int unsigned BAUD_TICK_DIV = CLK_HZ / (BAUD_RATE * OVERSAMPLE);

  typedef logic [7:0] byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side byte streams plus the serializer start/busy handshake.
// master = requesters and serializer, slave = the arbiter.
// Byte i of req_data lives on bits [8i+7:8i].
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  import uart_pkg::*;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_last;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 tx_start;
  byte_t                tx_data;
  logic                 tx_busy;

  modport master (
    output req_valid, req_data, req_last, tx_busy,
    input  req_ready, tx_start, tx_data
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_busy,
    output req_ready, tx_start, tx_data
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Round-robin selector: first asserted req at or after ptr, wrapping modulo N.
// Purely combinational, zero latency.
// No backpressure; any is low when nothing requests (idx is then 0).
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] idx,
  output logic                 any
);
  localparam int PW = $clog2(N);

  logic [PW:0] cand;

  // Scan offsets from farthest to nearest so the nearest asserted request wins.
  always_comb begin
    idx  = '0;
    any  = |req;
    cand = '0;
    for (int k = N - 1; k >= 0; k--) begin
      cand = {1'b0, ptr} + (PW + 1)'(k);
      if (cand >= (PW + 1)'(N)) begin
        cand = cand - (PW + 1)'(N);
      end
      if (req[cand[PW-1:0]]) begin
        idx = cand[PW-1:0];
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART TX serializer among NUM_REQ requesters, moving whole messages per grant.
// Latency: request->grant 1 cycle, accept->tx_start 1 cycle.
// Backpressure: req_ready only in SEND with serializer idle; grant rotates on last, burst cap or stall.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int MAX_BURST     = 16,
  parameter int STALL_TIMEOUT = 1024
) (
  input  logic                       clk,
  input  logic                       reset,
  uart_tx_arbiter_if.slave           bus,
  output logic                       grant_active_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       stall_abort_o
);
  localparam int              IW         = $clog2(NUM_REQ);
  localparam logic [7:0]      BURST_CAP  = 8'(MAX_BURST);
  localparam logic [15:0]     STALL_LAST = 16'(STALL_TIMEOUT - 1);
  localparam logic [IW-1:0]   LAST_ID    = IW'(NUM_REQ - 1);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] grant_id_q, grant_id_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          grant_active_q, grant_active_d;
  logic          last_q, last_d;
  logic          tx_start_q, tx_start_d;
  logic          stall_abort_q, stall_abort_d;
  byte_t         tx_data_q, tx_data_d;
  logic [7:0]    burst_cnt_q, burst_cnt_d;
  logic [15:0]   stall_cnt_q, stall_cnt_d;

  logic [IW-1:0] pick_idx;
  logic          pick_any;
  logic          g_valid;
  logic          g_last;
  byte_t         g_data;
  logic          send_rdy;
  logic          xfer;
  logic [IW-1:0] next_ptr;

  rr_pick #(.N(NUM_REQ)) u_rr_pick (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  // Select the owner's byte stream and derive the transfer condition.
  always_comb begin
    g_valid  = bus.req_valid[grant_id_q];
    g_last   = bus.req_last[grant_id_q];
    g_data   = bus.req_data[{grant_id_q, 3'b000} +: 8];
    send_rdy = (state_q == SEND) && !bus.tx_busy;
    xfer     = send_rdy && g_valid;
    next_ptr = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
  end

  // State and datapath registers; reset clears every visible output immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      grant_id_q     <= '0;
      rr_ptr_q       <= '0;
      grant_active_q <= 1'b0;
      last_q         <= 1'b0;
      tx_start_q     <= 1'b0;
      stall_abort_q  <= 1'b0;
      tx_data_q      <= '0;
      burst_cnt_q    <= '0;
      stall_cnt_q    <= '0;
    end else begin
      state_q        <= state_d;
      grant_id_q     <= grant_id_d;
      rr_ptr_q       <= rr_ptr_d;
      grant_active_q <= grant_active_d;
      last_q         <= last_d;
      tx_start_q     <= tx_start_d;
      stall_abort_q  <= stall_abort_d;
      tx_data_q      <= tx_data_d;
      burst_cnt_q    <= burst_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
    end
  end

  // Next state: grant in IDLE, accept/stall-count in SEND, rotate-or-continue in WAIT.
  always_comb begin
    state_d        = state_q;
    grant_id_d     = grant_id_q;
    rr_ptr_d       = rr_ptr_q;
    grant_active_d = grant_active_q;
    last_d         = last_q;
    tx_start_d     = 1'b0;
    stall_abort_d  = 1'b0;
    tx_data_d      = tx_data_q;
    burst_cnt_d    = burst_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_id_d     = pick_idx;
          grant_active_d = 1'b1;
          burst_cnt_d    = '0;
          stall_cnt_d    = '0;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (xfer) begin
          tx_data_d   = g_data;
          tx_start_d  = 1'b1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          last_d      = g_last;
          state_d     = WAIT;
        end else if (!bus.tx_busy) begin
          // Owner has nothing to offer while the serializer is free: count toward revocation.
          if (stall_cnt_q == STALL_LAST) begin
            stall_abort_d  = 1'b1;
            grant_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = IDLE;
          end else if (stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
          end
        end
      end
      WAIT: begin
        // tx_busy only rises the cycle after tx_start, so ignore it during the start pulse.
        if (!tx_start_q && !bus.tx_busy) begin
          if (last_q || (burst_cnt_q == BURST_CAP)) begin
            grant_active_d = 1'b0;
            rr_ptr_d       = next_ptr;
            state_d        = IDLE;
          end else begin
            stall_cnt_d = '0;
            state_d     = SEND;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: one-hot ready to the owner when the serializer can take a byte.
  always_comb begin
    bus.req_ready = '0;
    if (send_rdy) begin
      bus.req_ready[grant_id_q] = 1'b1;
    end
    bus.tx_start   = tx_start_q;
    bus.tx_data    = tx_data_q;
    grant_active_o = grant_active_q;
    grant_id_o     = grant_id_q;
    stall_abort_o  = stall_abort_q;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queued byte-stream requesters, behavioural serializer, rr reference model.
// Inputs driven on the falling edge; outputs sampled there too.
// Serializer busy length is randomized per byte to exercise backpressure.
module tb_uart_tx_arbiter;
  import uart_pkg::*;

  localparam int N  = 4;
  localparam int MB = 4;
  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       grant_active;
  logic [1:0] grant_id;
  logic       stall_abort;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .MAX_BURST(MB), .STALL_TIMEOUT(TO)) dut (
    .clk            (clk),
    .reset          (reset),
    .bus            (bus),
    .grant_active_o (grant_active),
    .grant_id_o     (grant_id),
    .stall_abort_o  (stall_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [8:0] rq [N][$];
  logic [8:0] mq [N][$];
  bit         hold [N];
  bit         hold_after_pop [N];
  int         obs_id [$];
  logic [7:0] obs_b [$];
  int         exp_id [$];
  logic [7:0] exp_b [$];
  int         busy_cnt = 0;
  int         busy_max = 8;
  logic [7:0] cur_byte = 8'h00;
  int         abort_cnt = 0;
  int         busy_fall_cyc = -1;
  int         ga_fall_cyc = -1;
  logic       ga_prev = 1'b0;
  logic       busy_prev;
  logic [N-1:0] ready_s;
  int         model_ptr = 0;

  // One clock cycle: monitor outputs, run the serializer model, drive requesters, complete handshakes.
  task automatic step();
    logic [N-1:0] oh;
    @(negedge clk);
    cyc++;
    if (bus.tx_start === 1'b1) begin
      checks++;
      if (busy_cnt != 0 || bus.tx_busy) begin
        errors++;
        $display("FAIL tx_start_overlap: tx_start=1 with serializer busy (remaining %0d), required no start", busy_cnt);
      end
      obs_id.push_back(int'(grant_id));
      obs_b.push_back(bus.tx_data);
      cur_byte = bus.tx_data;
    end
    if (stall_abort === 1'b1) abort_cnt++;
    if (ga_prev && !grant_active) ga_fall_cyc = cyc;
    ga_prev = grant_active;
    busy_prev = bus.tx_busy;
    bus.tx_busy = (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    if (bus.tx_start === 1'b1) busy_cnt = $urandom_range(1, busy_max);
    if (busy_prev && !bus.tx_busy) busy_fall_cyc = cyc;
    if (bus.tx_busy) begin
      checks++;
      if (bus.tx_data !== cur_byte) begin
        errors++;
        $display("FAIL tx_data_stable: tx_data=%02h during busy, required %02h", bus.tx_data, cur_byte);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (rq[i].size() > 0 && !hold[i]) begin
        bus.req_valid[i]       = 1'b1;
        bus.req_data[i*8 +: 8] = rq[i][0][7:0];
        bus.req_last[i]        = rq[i][0][8];
      end else begin
        bus.req_valid[i]       = 1'b0;
        bus.req_data[i*8 +: 8] = 8'($urandom);
        bus.req_last[i]        = 1'($urandom);
      end
    end
    #1;
    ready_s = bus.req_ready;
    oh = '0;
    oh[grant_id] = 1'b1;
    checks++;
    if (!$onehot0(ready_s) || (ready_s != '0 && (!grant_active || ready_s != oh)) ||
        (bus.tx_busy && ready_s != '0)) begin
      errors++;
      $display("FAIL ready_rule: req_ready=%b grant_active=%b grant_id=%0d tx_busy=%b, required zero or owner one-hot while idle serializer",
               ready_s, grant_active, grant_id, bus.tx_busy);
    end
    for (int i = 0; i < N; i++) begin
      if (bus.req_valid[i] && ready_s[i]) begin
        void'(rq[i].pop_front());
        if (hold_after_pop[i]) begin
          hold[i] = 1'b1;
          hold_after_pop[i] = 1'b0;
        end
      end
    end
  endtask

  // Step until every queue has drained and the grant and serializer are idle.
  task automatic run_idle(input int max_cyc, input string name);
    int  n;
    int  pend;
    bit  done;
    n = 0;
    done = 1'b0;
    while (!done && n < max_cyc) begin
      step();
      n++;
      pend = 0;
      for (int i = 0; i < N; i++) pend += rq[i].size();
      done = (pend == 0) && !grant_active && (busy_cnt == 0) && !bus.tx_busy;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: not idle after %0d cycles, required drain", name, max_cyc);
    end
  endtask

  // Hold reset across two edges and clear all bench-side state.
  task automatic do_reset();
    reset = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    bus.tx_busy   = 1'b0;
    busy_cnt = 0;
    ga_prev  = 1'b0;
    for (int i = 0; i < N; i++) begin
      rq[i].delete();
      hold[i] = 1'b0;
      hold_after_pop[i] = 1'b0;
    end
    obs_id.delete();
    obs_b.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Transaction-level arbiter: rr pick, then send until last byte or burst cap.
  task automatic build_expected();
    int         g;
    int         j;
    int         n;
    logic [8:0] b;
    exp_id.delete();
    exp_b.delete();
    for (int i = 0; i < N; i++) mq[i] = rq[i];
    while (1) begin
      g = -1;
      for (int k = 0; k < N; k++) begin
        j = (model_ptr + k) % N;
        if (g < 0 && mq[j].size() > 0) g = j;
      end
      if (g < 0) break;
      n = 0;
      do begin
        b = mq[g].pop_front();
        exp_id.push_back(g);
        exp_b.push_back(b[7:0]);
        n++;
      end while (!b[8] && n < MB && mq[g].size() > 0);
      model_ptr = (g + 1) % N;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks += 6;
    if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start: %b, required 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data: %02h, required 00", bus.tx_data); end
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: %b, required 0000", bus.req_ready); end
    if (grant_active !== 1'b0) begin errors++; $display("FAIL reset_grant_active: %b, required 0", grant_active); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant_id: %0d, required 0", grant_id); end
    if (stall_abort !== 1'b0) begin errors++; $display("FAIL reset_stall_abort: %b, required 0", stall_abort); end
  endtask

  task automatic test_single();
    do_reset();
    busy_max = 8;
    rq[0] = '{9'h041, 9'h042, 9'h143};
    exp_id = '{0, 0, 0};
    exp_b  = '{8'h41, 8'h42, 8'h43};
    busy_fall_cyc = -1;
    ga_fall_cyc = -1;
    run_idle(300, "single");
    checks++;
    if (obs_id.size() != exp_id.size()) begin errors++; $display("FAIL single_count: %0d starts, required %0d", obs_id.size(), exp_id.size()); end
    foreach (exp_id[k]) if (k < obs_id.size()) begin
      checks++;
      if (obs_id[k] != exp_id[k] || obs_b[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL single_seq[%0d]: id %0d byte %02h, required id %0d byte %02h", k, obs_id[k], obs_b[k], exp_id[k], exp_b[k]);
      end
    end
    checks++;
    if (busy_fall_cyc < 0 || ga_fall_cyc != busy_fall_cyc + 1) begin
      errors++;
      $display("FAIL single_release: grant_active fell at %0d, required %0d (cycle after busy fall)", ga_fall_cyc, busy_fall_cyc + 1);
    end
    // Pointer must now sit at 1, so requester 1 beats requester 0.
    obs_id.delete();
    obs_b.delete();
    rq[0] = '{9'h150};
    rq[1] = '{9'h151};
    exp_id = '{1, 0};
    exp_b  = '{8'h51, 8'h50};
    run_idle(300, "single_ptr");
    checks++;
    if (obs_id.size() != exp_id.size()) begin errors++; $display("FAIL single_ptr_count: %0d starts, required %0d", obs_id.size(), exp_id.size()); end
    foreach (exp_id[k]) if (k < obs_id.size()) begin
      checks++;
      if (obs_id[k] != exp_id[k] || obs_b[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL single_ptr_seq[%0d]: id %0d byte %02h, required id %0d byte %02h", k, obs_id[k], obs_b[k], exp_id[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_rr();
    do_reset();
    rq[1] = '{9'h1A1};
    rq[3] = '{9'h1A3};
    run_idle(300, "rr_a");
    rq[1] = '{9'h1B1};
    rq[0] = '{9'h1B0};
    run_idle(300, "rr_b");
    exp_id = '{1, 3, 0, 1};
    exp_b  = '{8'hA1, 8'hA3, 8'hB0, 8'hB1};
    checks++;
    if (obs_id.size() != exp_id.size()) begin errors++; $display("FAIL rr_count: %0d starts, required %0d", obs_id.size(), exp_id.size()); end
    foreach (exp_id[k]) if (k < obs_id.size()) begin
      checks++;
      if (obs_id[k] != exp_id[k] || obs_b[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL rr_seq[%0d]: id %0d byte %02h, required id %0d byte %02h", k, obs_id[k], obs_b[k], exp_id[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_burst();
    do_reset();
    rq[1] = '{9'h1C1};
    run_idle(300, "burst_a");
    rq[2] = '{9'h020, 9'h021, 9'h022, 9'h023, 9'h024, 9'h125};
    rq[0] = '{9'h030, 9'h031, 9'h132};
    run_idle(600, "burst_b");
    exp_id = '{1, 2, 2, 2, 2, 0, 0, 0, 2, 2};
    exp_b  = '{8'hC1, 8'h20, 8'h21, 8'h22, 8'h23, 8'h30, 8'h31, 8'h32, 8'h24, 8'h25};
    checks++;
    if (obs_id.size() != exp_id.size()) begin errors++; $display("FAIL burst_count: %0d starts, required %0d", obs_id.size(), exp_id.size()); end
    foreach (exp_id[k]) if (k < obs_id.size()) begin
      checks++;
      if (obs_id[k] != exp_id[k] || obs_b[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL burst_seq[%0d]: id %0d byte %02h, required id %0d byte %02h", k, obs_id[k], obs_b[k], exp_id[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_stall();
    int  n;
    int  t0;
    bit  seen;
    do_reset();
    abort_cnt = 0;
    rq[1] = '{9'h055, 9'h156};
    hold_after_pop[1] = 1'b1;
    n = 0;
    while (obs_id.size() < 1 && n < 200) begin step(); n++; end
    rq[0].push_back(9'h160);
    t0 = -1;
    seen = 1'b0;
    n = 0;
    while (!seen && n < TO + 200) begin
      step();
      n++;
      if (t0 < 0 && ready_s[1]) t0 = cyc;
      if (stall_abort === 1'b1) begin
        seen = 1'b1;
        checks += 2;
        if (t0 < 0 || cyc - t0 != TO) begin
          errors++;
          $display("FAIL stall_timing: abort %0d cycles after SEND entry, required %0d", cyc - t0, TO);
        end
        if (grant_active !== 1'b0) begin
          errors++;
          $display("FAIL stall_release: grant_active=%b at abort, required 0", grant_active);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL stall_abort_missing: no abort in %0d cycles, required one", n); end
    hold[1] = 1'b0;
    run_idle(400, "stall");
    checks++;
    if (abort_cnt != 1) begin errors++; $display("FAIL stall_pulses: %0d abort cycles, required 1", abort_cnt); end
    exp_id = '{1, 0, 1};
    exp_b  = '{8'h55, 8'h60, 8'h56};
    checks++;
    if (obs_id.size() != exp_id.size()) begin errors++; $display("FAIL stall_count: %0d starts, required %0d", obs_id.size(), exp_id.size()); end
    foreach (exp_id[k]) if (k < obs_id.size()) begin
      checks++;
      if (obs_id[k] != exp_id[k] || obs_b[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL stall_seq[%0d]: id %0d byte %02h, required id %0d byte %02h", k, obs_id[k], obs_b[k], exp_id[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_reset_wait();
    int n;
    do_reset();
    // First message moves the pointer off zero; reset must bring it back.
    rq[2] = '{9'h170, 9'h077, 9'h178};
    n = 0;
    while (obs_id.size() < 2 && n < 300) begin step(); n++; end
    checks++;
    if (obs_id.size() < 2) begin errors++; $display("FAIL rstw_setup: %0d starts, required 2", obs_id.size()); end
    #2 reset = 1'b1;
    #1;
    checks += 6;
    if (bus.tx_start !== 1'b0) begin errors++; $display("FAIL rstw_tx_start: %b, required 0", bus.tx_start); end
    if (bus.tx_data !== 8'h00) begin errors++; $display("FAIL rstw_tx_data: %02h, required 00", bus.tx_data); end
    if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL rstw_req_ready: %b, required 0000", bus.req_ready); end
    if (grant_active !== 1'b0) begin errors++; $display("FAIL rstw_grant_active: %b, required 0", grant_active); end
    if (grant_id !== 2'd0) begin errors++; $display("FAIL rstw_grant_id: %0d, required 0", grant_id); end
    if (stall_abort !== 1'b0) begin errors++; $display("FAIL rstw_stall_abort: %b, required 0", stall_abort); end
    do_reset();
    rq[3] = '{9'h1D3};
    rq[1] = '{9'h1D1};
    run_idle(300, "rstw");
    exp_id = '{1, 3};
    exp_b  = '{8'hD1, 8'hD3};
    checks++;
    if (obs_id.size() != exp_id.size()) begin errors++; $display("FAIL rstw_count: %0d starts, required %0d", obs_id.size(), exp_id.size()); end
    foreach (exp_id[k]) if (k < obs_id.size()) begin
      checks++;
      if (obs_id[k] != exp_id[k] || obs_b[k] !== exp_b[k]) begin
        errors++;
        $display("FAIL rstw_seq[%0d]: id %0d byte %02h, required id %0d byte %02h", k, obs_id[k], obs_b[k], exp_id[k], exp_b[k]);
      end
    end
  endtask

  task automatic test_random();
    int len;
    do_reset();
    model_ptr = 0;
    for (int it = 0; it < 10; it++) begin
      busy_max = $urandom_range(1, 10);
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) != 0) begin
          for (int m = 0; m < int'($urandom_range(1, 2)); m++) begin
            len = $urandom_range(1, 7);
            for (int b = 0; b < len; b++) rq[i].push_back({(b == len - 1), 8'($urandom)});
          end
        end
      end
      build_expected();
      obs_id.delete();
      obs_b.delete();
      run_idle(4000, "random");
      checks++;
      if (obs_id.size() != exp_id.size()) begin
        errors++;
        $display("FAIL random_count[%0d]: %0d starts, required %0d", it, obs_id.size(), exp_id.size());
      end
      foreach (exp_id[k]) if (k < obs_id.size()) begin
        checks++;
        if (obs_id[k] != exp_id[k] || obs_b[k] !== exp_b[k]) begin
          errors++;
          $display("FAIL random_seq[%0d.%0d]: id %0d byte %02h, required id %0d byte %02h", it, k, obs_id[k], obs_b[k], exp_id[k], exp_b[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_burst();
    test_stall();
    test_reset_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation still running at time limit, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares one byte-wide UART transmitter among `NUM_REQ` requesters (command responder, status reporter, debug echo, and others). It moves whole messages: once a requester is granted, its bytes go out back-to-back until its `last` byte is sent, a burst cap is reached, or it stalls too long. It sits between the requester logic and the 100 MHz UART TX serializer, which runs at 9600 baud with 16x oversampling.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `MAX_BURST`, 16: maximum bytes per grant before forced rotation, 1..255.
- `STALL_TIMEOUT`, 1024: cycles a granted requester may hold `req_valid` low mid-message before the grant is revoked, 2..65535.
- `clk` input 1: 100 MHz clock.
- `reset` input 1: asynchronous, active-high.
- `req_valid` input `NUM_REQ`: per-requester byte-valid.
- `req_data` input `NUM_REQ*8`: requester i byte is on bits [8i+7:8i].
- `req_last` input `NUM_REQ`: byte is the final one of its message.
- `req_ready` output `NUM_REQ`: byte accepted; one-hot or zero.
- `tx_start` output 1: one-cycle start pulse to the serializer.
- `tx_data` output 8: byte to serialize; stable from `tx_start` until `tx_busy` falls.
- `tx_busy` input 1: serializer busy. It rises the cycle after `tx_start` and stays high through the stop bit.
- `grant_active` output 1: a requester currently owns the transmitter.
- `grant_id` output `$clog2(NUM_REQ)`: index of the owner; valid while `grant_active` is high.
- `stall_abort` output 1: one-cycle pulse when a grant is revoked by timeout.

## Operation
- Handshake: a byte transfers on a cycle with `req_valid[g] && req_ready[g]`. `req_ready[g]` is combinational: `state==SEND && !tx_busy`.
- States:
  - `IDLE`: if any `req_valid` is high, pick the first valid index at or after `rr_ptr`, wrapping modulo `NUM_REQ`. Register `grant_id`, set `grant_active`, clear `burst_cnt` and `stall_cnt`, and go to `SEND`.
  - `SEND`: on transfer, register `tx_data<=req_data[g]`, pulse `tx_start` the next cycle, `burst_cnt++`, latch `last_q<=req_last[g]`, and go to `WAIT`. While `req_valid[g]` is low, `stall_cnt++`. At `STALL_TIMEOUT-1`, pulse `stall_abort` and release the grant.
  - `WAIT`: skip the `tx_start` cycle, then wait for `tx_busy==0`. Then:
    - release if `last_q` or `burst_cnt==MAX_BURST`;
    - otherwise clear `stall_cnt` and return to `SEND`.
- Release: `grant_active<=0`, `rr_ptr<=(grant_id+1) mod NUM_REQ`, go to `IDLE`.
- Burst-cap rotation does not end the message. The requester re-arbitrates and continues later; other requesters' bytes may be interleaved between bursts.
- `req_data` and `req_last` of non-granted requesters are ignored. Their `req_ready` stays 0.
- Stall abort drops nothing already accepted. The requester re-arbitrates for the remainder of its message.
- `burst_cnt` is 8 bits. `stall_cnt` is 16 bits and saturates.

## Timing
- Reset values: `tx_start`=0, `tx_data`=0, `req_ready`=0, `grant_active`=0, `grant_id`=0, `stall_abort`=0, state `IDLE`, `rr_ptr`=0.
- Request to grant: 1 cycle (`IDLE` to `SEND`). The earliest `req_ready` is 1 cycle after `req_valid` rises in `IDLE`.
- Accept to `tx_start`: 1 cycle.
- Inter-byte gap within a grant: 2 cycles after `tx_busy` falls, then the next accept.
- Release to new grant: 1 cycle in `IDLE`. The single-requester-only case re-grants the same index.
- A requester that drops `req_valid` in the same cycle the arbiter would sample it in `IDLE` is simply not chosen; no glitch on `req_ready`.
- Reset mid-byte: all outputs return to reset values at once. The serializer's own reset handles the byte on the line.
- `tx_busy` high while in `SEND` (serializer not yet idle): `req_ready` is held low and the stall counter does not advance.

## Structure
- Shared package `uart_pkg`:
  - state enum (`IDLE`, `SEND`, `WAIT`);
  - `CLK_HZ=100_000_000`, `BAUD_RATE=9600`, oversample factor 16;
  - byte typedef.
- Sub-module `rr_pick`: combinational round-robin selector with inputs `req`, `ptr` and outputs `idx`, `any`. It is reused by other arbiters.

## Test plan
- Single requester 0 sends 3 bytes 0x41, 0x42, 0x43 (`last` on 0x43) -> three `tx_start` pulses carrying those bytes in order; `grant_active` falls after the third `tx_busy` fall; `rr_ptr`=1.
- Requesters 1 and 3 request together from reset (`rr_ptr`=0) -> 1 granted first; after its 1-byte message, 3 is granted; then requester 1 requests again and wins over a later request from 0 only if `rr_ptr` favours it (ptr=0 -> 0 wins).
- `MAX_BURST`=4, requester 2 sends a 6-byte message while requester 0 waits -> 4 bytes from 2, then 0's message, then the remaining 2 bytes from 2.
- Granted requester drops `req_valid` after byte 1 for `STALL_TIMEOUT` cycles -> `stall_abort` pulses once at cycle `STALL_TIMEOUT`; grant passes on; no extra `tx_start`.
- Assert `reset` while in `WAIT` -> all outputs 0 in the same cycle; after release, a new request is granted normally with `rr_ptr`=0.
- Hold `tx_busy` high for an extra 5 cycles after a byte -> `req_ready` stays low until it falls; there is never more than one `tx_start` per `tx_busy` period.
